priority_resolver_n: RTL and testbench

//  Parametrised, stateful priority resolver for an N-input PIC. Owns the in-service register (ISR),

---
 rtl/priority_resolver_n.sv | 153 +++++++++++++++
 tb/tb_priority_resolver_n.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/priority_resolver_n.sv
// Stateful N-input PIC priority resolver: in-service register, rotating priority base and the
// request/acknowledge handshake toward the CPU.
module priority_resolver_n #(
  parameter int unsigned NUM_IRQ = 8,
  parameter int unsigned ID_W    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_request,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               special_mask_mode,
  input  logic               auto_rotate,
  input  logic               auto_eoi,
  input  logic               set_priority,
  input  logic [ID_W-1:0]    priority_level,
  input  logic               ack,
  input  logic               eoi,
  input  logic               eoi_specific,
  input  logic [ID_W-1:0]    eoi_level,
  output logic               int_req,
  output logic [ID_W-1:0]    int_vector,
  output logic [NUM_IRQ-1:0] in_service,
  output logic [ID_W-1:0]    priority_base
);

  typedef enum logic [1:0] {StIdle, StReq, StAck} state_e;

  localparam logic [ID_W:0]   NumW    = (ID_W+1)'(NUM_IRQ);
  localparam logic [ID_W-1:0] LastLvl = ID_W'(NUM_IRQ - 1);

  state_e               state_q;
  logic                 int_req_q;
  logic [ID_W-1:0]      vec_q;
  logic [NUM_IRQ-1:0]   isr_q, isr_d;
  logic [ID_W-1:0]      base_q, base_d;

  // Level sitting at priority position p counted from base, wrapping at NUM_IRQ.
  function automatic logic [ID_W-1:0] lvl_at(input logic [ID_W-1:0] base, input int unsigned p);
    logic [ID_W:0] sum;
    sum = {1'b0, base} + (ID_W+1)'(p);
    if (sum >= NumW) sum = sum - NumW;
    return sum[ID_W-1:0];
  endfunction

  function automatic logic [ID_W-1:0] next_lvl(input logic [ID_W-1:0] lvl);
    return (lvl == LastLvl) ? '0 : lvl + 1'b1;
  endfunction

  function automatic logic in_range(input logic [ID_W-1:0] lvl);
    return {1'b0, lvl} < NumW;
  endfunction

  logic [NUM_IRQ-1:0] eligible, blocking;
  logic               win_found, win_stop;
  logic [ID_W-1:0]    win_lvl, win_scan;

  // Scan from base; the first blocking ISR bit (same level included) ends the search.
  always_comb begin
    eligible  = irq_request & ~irq_mask;
    blocking  = special_mask_mode ? (isr_q & ~irq_mask) : isr_q;
    win_found = 1'b0;
    win_stop  = 1'b0;
    win_lvl   = '0;
    win_scan  = '0;
    for (int unsigned p = 0; p < NUM_IRQ; p++) begin
      win_scan = lvl_at(base_q, p);
      if (!win_stop) begin
        if (blocking[win_scan]) begin
          win_stop = 1'b1;
        end else if (eligible[win_scan]) begin
          win_found = 1'b1;
          win_lvl   = win_scan;
          win_stop  = 1'b1;
        end
      end
    end
  end

  logic            eoi_found;
  logic [ID_W-1:0] eoi_top, eoi_scan;

  always_comb begin
    eoi_found = 1'b0;
    eoi_top   = '0;
    eoi_scan  = '0;
    for (int unsigned p = 0; p < NUM_IRQ; p++) begin
      eoi_scan = lvl_at(base_q, p);
      if (!eoi_found && isr_q[eoi_scan]) begin
        eoi_found = 1'b1;
        eoi_top   = eoi_scan;
      end
    end
  end

  // EOI clears act on the old ISR, the ack set is ORed in afterwards; set_priority wins last.
  always_comb begin
    isr_d  = isr_q;
    base_d = base_q;
    if (eoi && eoi_found) begin
      isr_d[eoi_top] = 1'b0;
      if (auto_rotate) base_d = next_lvl(eoi_top);
    end
    if (eoi_specific && in_range(eoi_level)) isr_d[eoi_level] = 1'b0;
    if (state_q == StReq && ack && win_found) begin
      if (!auto_eoi) begin
        isr_d[win_lvl] = 1'b1;
      end else if (auto_rotate) begin
        base_d = next_lvl(win_lvl);
      end
    end
    if (set_priority && in_range(priority_level)) base_d = next_lvl(priority_level);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      int_req_q <= 1'b0;
      vec_q     <= '0;
      isr_q     <= '0;
      base_q    <= '0;
    end else begin
      isr_q  <= isr_d;
      base_q <= base_d;
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            state_q   <= StReq;
            int_req_q <= 1'b1;
            vec_q     <= win_lvl;
          end
        end
        StReq: begin
          if (ack) begin
            state_q   <= StAck;
            int_req_q <= 1'b0;
            // A withdrawn request still completes the handshake with the spurious vector.
            vec_q     <= win_found ? win_lvl : LastLvl;
          end else if (win_found) begin
            vec_q <= win_lvl;
          end
        end
        StAck: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign int_req       = int_req_q;
  assign int_vector    = vec_q;
  assign in_service    = isr_q;
  assign priority_base = base_q;

endmodule

// File: tb/tb_priority_resolver_n.sv
// Scoreboard bench for priority_resolver_n: a cycle model predicts every output update, a monitor
// compares; a second 5-input instance covers the non-power-of-two wrap.
module tb_priority_resolver_n;
  localparam int NI = 8;
  localparam int IW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [NI-1:0] irq_request, irq_mask;
  logic          smm, ar, aeoi, set_priority, ack, eoi, eoi_specific;
  logic [IW-1:0] priority_level, eoi_level;
  logic          int_req;
  logic [IW-1:0] int_vector, priority_base;
  logic [NI-1:0] in_service;

  priority_resolver_n #(.NUM_IRQ(NI), .ID_W(IW)) u_dut (
    .clock(clock), .reset(reset), .irq_request(irq_request), .irq_mask(irq_mask),
    .special_mask_mode(smm), .auto_rotate(ar), .auto_eoi(aeoi), .set_priority(set_priority),
    .priority_level(priority_level), .ack(ack), .eoi(eoi), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .int_req(int_req), .int_vector(int_vector),
    .in_service(in_service), .priority_base(priority_base)
  );

  // 5-input instance
  logic       rst5, r5_ar, r5_sp, r5_ack, r5_eoi;
  logic [4:0] r5_req, o5_isr;
  logic [2:0] r5_plvl, o5_vec, o5_base;
  logic       o5_req;

  priority_resolver_n #(.NUM_IRQ(5), .ID_W(3)) u_dut5 (
    .clock(clock), .reset(rst5), .irq_request(r5_req), .irq_mask(5'b0),
    .special_mask_mode(1'b0), .auto_rotate(r5_ar), .auto_eoi(1'b0), .set_priority(r5_sp),
    .priority_level(r5_plvl), .ack(r5_ack), .eoi(r5_eoi), .eoi_specific(1'b0),
    .eoi_level(3'd0), .int_req(o5_req), .int_vector(o5_vec),
    .in_service(o5_isr), .priority_base(o5_base)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Level stimulus, applied to the DUT only at the falling edge
  logic [NI-1:0] s_req, s_mask;
  logic          s_smm, s_ar, s_aeoi;
  logic [IW-1:0] s_plvl, s_elvl;

  // Reference model: 0 idle, 1 requesting, 2 acknowledged
  int        m_state, m_base, m_vec;
  bit        m_req;
  bit [NI-1:0] m_isr;

  typedef struct {
    bit          req;
    int          vec;
    bit [NI-1:0] isr;
    int          base;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, act, expv);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_base = 0; m_vec = 0; m_req = 1'b0; m_isr = '0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit a, input bit e, input bit es, input bit sp);
    bit [NI-1:0] elig, blk, nisr;
    int w, nbase, l;
    elig = s_req & ~s_mask;
    blk  = s_smm ? (m_isr & ~s_mask) : m_isr;
    w = -1;
    for (int p = 0; p < NI; p++) begin
      l = (m_base + p) % NI;
      if (blk[IW'(l)]) break;
      if (elig[IW'(l)]) begin
        w = l;
        break;
      end
    end
    nisr  = m_isr;
    nbase = m_base;
    if (e) begin
      for (int p = 0; p < NI; p++) begin
        l = (m_base + p) % NI;
        if (m_isr[IW'(l)]) begin
          nisr[IW'(l)] = 1'b0;
          if (s_ar) nbase = (l + 1) % NI;
          break;
        end
      end
    end
    if (es && int'(s_elvl) < NI) nisr[s_elvl] = 1'b0;
    case (m_state)
      0: if (w >= 0) begin m_state = 1; m_req = 1'b1; m_vec = w; end
      1: begin
        if (a) begin
          m_state = 2;
          m_req   = 1'b0;
          if (w >= 0) begin
            m_vec = w;
            if (!s_aeoi) nisr[IW'(w)] = 1'b1;
            else if (s_ar) nbase = (w + 1) % NI;
          end else begin
            m_vec = NI - 1;
          end
        end else if (w >= 0) begin
          m_vec = w;
        end
      end
      default: m_state = 0;
    endcase
    if (sp && int'(s_plvl) < NI) nbase = (int'(s_plvl) + 1) % NI;
    m_isr  = nisr;
    m_base = nbase;
    exp_q.push_back('{m_req, m_vec, m_isr, m_base});
  endtask

  task automatic apply(input bit a, input bit e, input bit es, input bit sp);
    irq_request = s_req; irq_mask = s_mask; smm = s_smm; ar = s_ar; aeoi = s_aeoi;
    priority_level = s_plvl; eoi_level = s_elvl;
    ack = a; eoi = e; eoi_specific = es; set_priority = sp;
    model_step(a, e, es, sp);
  endtask

  task automatic step(input bit a = 0, input bit e = 0, input bit es = 0, input bit sp = 0);
    @(negedge clock);
    apply(a, e, es, sp);
  endtask

  task automatic clear_levels();
    s_req = '0; s_mask = '0; s_smm = 1'b0; s_ar = 1'b0; s_aeoi = 1'b0; s_plvl = '0; s_elvl = '0;
  endtask

  // Reset lands between edges so only the asynchronous path can clear the outputs.
  task automatic async_reset8();
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("rst_int_req", int'(int_req), 0);
    chk("rst_vector", int'(int_vector), 0);
    chk("rst_isr", int'(in_service), 0);
    chk("rst_base", int'(priority_base), 0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    apply(0, 0, 0, 0);
  endtask

  // Monitor: one comparison per clock against the oldest prediction
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (!reset && exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        checks++;
        if (int_req !== x.req || int_vector !== IW'(x.vec) || in_service !== x.isr ||
            priority_base !== IW'(x.base)) begin
          errors++;
          $display("FAIL cycle t=%0t got req=%0b vec=%0d isr=%h base=%0d exp req=%0b vec=%0d isr=%h base=%0d",
                   $time, int_req, int_vector, in_service, priority_base,
                   x.req, x.vec, x.isr, x.base);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; rst5 = 1'b1;
    clear_levels();
    model_reset();
    irq_request = '0; irq_mask = '0; smm = 0; ar = 0; aeoi = 0; set_priority = 0;
    priority_level = '0; ack = 0; eoi = 0; eoi_specific = 0; eoi_level = '0;
    r5_req = '0; r5_ar = 0; r5_sp = 0; r5_ack = 0; r5_eoi = 0; r5_plvl = '0;
    #3;
    chk("init_int_req", int'(int_req), 0);
    chk("init_isr", int'(in_service), 0);
    @(negedge clock);
    reset = 1'b0;
    apply(0, 0, 0, 0);

    // Fixed mode, nested blocking and EOI release
    s_req = 8'h84; step(); step(); step(1);
    s_req = 8'h80; step(); step(); step(); step(0, 1); step(); step(); step(1); step(); step(0, 1);
    async_reset8();

    // Higher level nests over ISR, lower level blocked
    s_req = 8'h10; step(); step(1); s_req = 8'h00; step();
    s_req = 8'h02; step(); step(); step(1); s_req = 8'h40; step(); step(); step();
    step(0, 1); step(); step(0, 1); step(); step(); step(1);
    async_reset8();

    // Auto rotation on non-specific EOI
    s_ar = 1'b1; s_req = 8'h08; step(); step(1); s_req = 8'h00; step(); step(0, 1);
    s_req = 8'h09; step(); step(); step(1); step();
    async_reset8();

    // Specific rotation and special mask
    s_plvl = 3'd5; step(0, 0, 0, 1); s_req = 8'h41; step(); step(); step(1);
    s_req = 8'h04; step(); step(); s_smm = 1'b1; s_mask = 8'h40; step(); step(); step(1); step();
    s_elvl = 3'd6; step(0, 0, 1); step();
    async_reset8();

    // Withdrawn request, then ack and EOI in the same cycle
    s_req = 8'h20; step(); step(); s_req = 8'h00; step(); step(); step(1); step();
    s_req = 8'h20; step(); step(1); step(); s_req = 8'h22; step(); step(); step(1, 1); step();
    s_aeoi = 1'b1; s_ar = 1'b1; s_req = 8'h08; step(0, 1); step(); step(1); step();
    s_req = 8'h04; step(); step(); async_reset8();

    // Randomized traffic
    clear_levels();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) s_req = NI'($urandom & $urandom);
      if ($urandom_range(0, 39) == 0) s_mask = NI'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 49) == 0) s_smm = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) s_ar = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) s_aeoi = 1'($urandom_range(0, 1));
      s_plvl = IW'($urandom_range(0, NI - 1));
      s_elvl = IW'($urandom_range(0, NI - 1));
      if ($urandom_range(0, 299) == 0) async_reset8();
      else step($urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
    end
    clear_levels();
    step(); step();

    // Five inputs: wrap at 5, out-of-range level ignored, async reset in request
    @(negedge clock); rst5 = 1'b0;
    r5_plvl = 3'd3; r5_sp = 1'b1; @(negedge clock); r5_sp = 1'b0;
    chk("n5_base_set", int'(o5_base), 4);
    r5_req = 5'b10000; @(negedge clock);
    chk("n5_int_req", int'(o5_req), 1);
    chk("n5_vector", int'(o5_vec), 4);
    r5_ack = 1'b1; @(negedge clock); r5_ack = 1'b0; r5_req = '0;
    chk("n5_isr_ack", int'(o5_isr), 16);
    chk("n5_req_low", int'(o5_req), 0);
    r5_ar = 1'b1; r5_eoi = 1'b1; @(negedge clock); r5_eoi = 1'b0;
    chk("n5_isr_eoi", int'(o5_isr), 0);
    chk("n5_base_wrap", int'(o5_base), 0);
    r5_plvl = 3'd2; r5_sp = 1'b1; @(negedge clock); r5_sp = 1'b0;
    chk("n5_base_lvl2", int'(o5_base), 3);
    r5_plvl = 3'd6; r5_sp = 1'b1; @(negedge clock); r5_sp = 1'b0;
    chk("n5_base_oob", int'(o5_base), 3);
    r5_req = 5'b00010; @(negedge clock);
    chk("n5_req_b1", int'(o5_req), 1);
    chk("n5_vec_b1", int'(o5_vec), 1);
    #2 rst5 = 1'b1;
    #1;
    chk("n5_rst_req", int'(o5_req), 0);
    chk("n5_rst_vec", int'(o5_vec), 0);
    chk("n5_rst_base", int'(o5_base), 0);
    @(negedge clock); rst5 = 1'b0; r5_req = '0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
